// File: rtl/timer_service_master_pkg.sv
// Shared constants, bus command payload and FSM encoding for the interval-timer master.
package timer_service_master_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PERIOD_W = 32;

  // Timer slave register map
  localparam logic [ADDR_W-1:0] REG_ST   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CTRL = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PL   = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PH   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_SL   = 3'd4;
  localparam logic [ADDR_W-1:0] REG_SH   = 3'd5;

  // Control register bit positions
  localparam int unsigned CTRL_ITO_BIT   = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT  = 3;

  localparam logic [3:0] CTRL_RUN_DEF =
    4'((1 << CTRL_ITO_BIT) | (1 << CTRL_CONT_BIT) | (1 << CTRL_START_BIT));
  localparam logic [3:0] CTRL_STP_DEF = 4'(1 << CTRL_STOP_BIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_GAP,
    S_WR_CTRL,
    S_RUN,
    S_STOP_WR,
    S_CLR_ST,
    S_CLR_GAP,
    S_SN_WR,
    S_SN_RL,
    S_SN_RH,
    S_SN_CAP
  } state_e;

  // One bus cycle worth of initiator outputs
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
  } avm_cmd_t;

  function automatic avm_cmd_t avm_idle();
    return '{address: '0, chipselect: 1'b0, write_n: 1'b1, writedata: '0};
  endfunction

  function automatic avm_cmd_t avm_wr(input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] data);
    return '{address: addr, chipselect: 1'b1, write_n: 1'b0, writedata: data};
  endfunction

  function automatic avm_cmd_t avm_rd(input logic [ADDR_W-1:0] addr);
    return '{address: addr, chipselect: 1'b1, write_n: 1'b1, writedata: '0};
  endfunction

endpackage

// File: rtl/timer_service_master_if.sv
// Avalon-MM link between the timer master and the timer s1 slave, plus the slave IRQ.
interface timer_service_master_if;
  import timer_service_master_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, timer_irq
  );
endinterface

// File: rtl/timer_service_master.sv
// Avalon-MM initiator that programs, runs, services, stops and snapshots an interval timer.
module timer_service_master
  import timer_service_master_pkg::*;
#(
  parameter int unsigned TICK_W   = 16,
  parameter logic [3:0]  CTRL_RUN = CTRL_RUN_DEF,
  parameter logic [3:0]  CTRL_STP = CTRL_STP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic                cfg_snap,
  timer_service_master_if.master avm,
  output logic                busy,
  output logic                running,
  output logic                tick_pulse,
  output logic [TICK_W-1:0]   tick_count,
  output logic [31:0]         snap_value,
  output logic                snap_valid,
  output logic                cfg_err
);

  state_e state_q, state_d;

  avm_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] period_hi_q, period_hi_d;
  logic [DATA_W-1:0] snap_lo_q, snap_lo_d;
  logic              stop_pend_q, stop_pend_d;
  logic              snap_pend_q, snap_pend_d;
  logic              busy_q, busy_d;
  logic              running_q, running_d;
  logic              tick_pulse_q, tick_pulse_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic [31:0]       snap_value_q, snap_value_d;
  logic              snap_valid_q, snap_valid_d;
  logic              cfg_err_q, cfg_err_d;

  logic start_ok_c;
  logic stop_go_c;
  logic irq_go_c;
  logic snap_go_c;

  // RUN dispatch: stop beats irq beats snapshot
  assign start_ok_c = (state_q == S_IDLE) && cfg_start && (cfg_period != '0);
  assign stop_go_c  = (state_q == S_RUN) && (stop_pend_q || cfg_stop);
  assign irq_go_c   = (state_q == S_RUN) && !stop_go_c && avm.timer_irq;
  assign snap_go_c  = (state_q == S_RUN) && !stop_go_c && !avm.timer_irq &&
                      (snap_pend_q || cfg_snap);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_ok_c) state_d = S_WR_PL;
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_GAP;
      S_GAP:     state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_RUN;
      S_RUN: begin
        if (stop_go_c)      state_d = S_STOP_WR;
        else if (irq_go_c)  state_d = S_CLR_ST;
        else if (snap_go_c) state_d = S_SN_WR;
      end
      S_STOP_WR: state_d = S_IDLE;
      S_CLR_ST:  state_d = S_CLR_GAP;
      S_CLR_GAP: state_d = S_RUN;
      S_SN_WR:   state_d = S_SN_RL;
      S_SN_RL:   state_d = S_SN_RH;
      S_SN_RH:   state_d = S_SN_CAP;
      S_SN_CAP:  state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; bus command is derived from the state being entered
  always_comb begin
    cmd_d        = avm_idle();
    period_hi_d  = period_hi_q;
    snap_lo_d    = snap_lo_q;
    stop_pend_d  = stop_pend_q;
    snap_pend_d  = snap_pend_q;
    busy_d       = (state_d != S_IDLE);
    running_d    = running_q;
    tick_pulse_d = 1'b0;
    tick_count_d = tick_count_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    cfg_err_d    = (state_q == S_IDLE) && cfg_start && (cfg_period == '0);

    unique case (state_d)
      S_WR_PL:   cmd_d = avm_wr(REG_PL, cfg_period[15:0]);
      S_WR_PH:   cmd_d = avm_wr(REG_PH, period_hi_q);
      S_WR_CTRL: cmd_d = avm_wr(REG_CTRL, DATA_W'(CTRL_RUN));
      S_STOP_WR: cmd_d = avm_wr(REG_CTRL, DATA_W'(CTRL_STP));
      S_CLR_ST:  cmd_d = avm_wr(REG_ST, '0);
      S_SN_WR:   cmd_d = avm_wr(REG_SL, '0);
      S_SN_RL:   cmd_d = avm_rd(REG_SL);
      S_SN_RH:   cmd_d = avm_rd(REG_SH);
      default:   cmd_d = avm_idle();
    endcase

    if (start_ok_c) begin
      period_hi_d  = cfg_period[31:16];
      tick_count_d = '0;
      running_d    = 1'b0;
    end
    if (state_q == S_WR_CTRL) running_d = 1'b1;
    if (state_q == S_STOP_WR) running_d = 1'b0;

    if (state_q == S_CLR_ST) begin
      tick_count_d = tick_count_q + TICK_W'(1);
      tick_pulse_d = 1'b1;
    end

    if (state_q == S_SN_RH) snap_lo_d = avm.avm_readdata;
    if (state_q == S_SN_CAP) begin
      snap_value_d = {avm.avm_readdata, snap_lo_q};
      snap_valid_d = 1'b1;
    end

    // Sticky requests only while a sequence is active; a dispatched stop drops any snapshot
    if (state_q != S_IDLE) begin
      if (cfg_stop) stop_pend_d = 1'b1;
      if (cfg_snap) snap_pend_d = 1'b1;
    end
    if (snap_go_c) snap_pend_d = 1'b0;
    if (stop_go_c) begin
      stop_pend_d = 1'b0;
      snap_pend_d = 1'b0;
    end
    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
      snap_pend_d = 1'b0;
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q        <= avm_idle();
      period_hi_q  <= '0;
      snap_lo_q    <= '0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_pulse_q <= 1'b0;
      tick_count_q <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      period_hi_q  <= period_hi_d;
      snap_lo_q    <= snap_lo_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      tick_pulse_q <= tick_pulse_d;
      tick_count_q <= tick_count_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign avm.avm_address    = cmd_q.address;
  assign avm.avm_chipselect = cmd_q.chipselect;
  assign avm.avm_write_n    = cmd_q.write_n;
  assign avm.avm_writedata  = cmd_q.writedata;

  assign busy       = busy_q;
  assign running    = running_q;
  assign tick_pulse = tick_pulse_q;
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_timer_service_master.sv
// Bench for timer_service_master paired with a behavioural interval-timer slave.
module tb_timer_service_master;
  import timer_service_master_pkg::*;

  localparam int unsigned TICK_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       cfg_period = '0;
  logic              cfg_start = 1'b0;
  logic              cfg_stop = 1'b0;
  logic              cfg_snap = 1'b0;
  logic              busy, running, tick_pulse, snap_valid, cfg_err;
  logic [TICK_W-1:0] tick_count;
  logic [31:0]       snap_value;

  timer_service_master_if avm_if ();

  timer_service_master #(.TICK_W(TICK_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_period (cfg_period),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .cfg_snap   (cfg_snap),
    .avm        (avm_if),
    .busy       (busy),
    .running    (running),
    .tick_pulse (tick_pulse),
    .tick_count (tick_count),
    .snap_value (snap_value),
    .snap_valid (snap_valid),
    .cfg_err    (cfg_err)
  );

  always #10 clk = ~clk;

  // Timer slave model: down-counter, 1-bit timeout status, snapshot latch, registered reads
  logic        sl_to = 1'b0;
  logic [3:0]  sl_ctrl = '0;
  logic [31:0] sl_period = '0;
  logic [31:0] sl_cnt = '0;
  logic [31:0] sl_snap = '0;
  logic        sl_run = 1'b0;
  logic [15:0] sl_rdata = '0;

  assign avm_if.avm_readdata = sl_rdata;
  assign avm_if.timer_irq    = sl_to & sl_ctrl[CTRL_ITO_BIT];

  always @(posedge clk) begin
    if (sl_run) begin
      if (sl_cnt == 0) begin
        sl_to  <= 1'b1;
        sl_cnt <= sl_period;
        if (!sl_ctrl[CTRL_CONT_BIT]) sl_run <= 1'b0;
      end else begin
        sl_cnt <= sl_cnt - 1;
      end
    end
    if (avm_if.avm_chipselect && !avm_if.avm_write_n) begin
      case (avm_if.avm_address)
        REG_ST:   sl_to <= 1'b0;
        REG_CTRL: begin
          sl_ctrl <= avm_if.avm_writedata[3:0];
          if (avm_if.avm_writedata[CTRL_STOP_BIT])       sl_run <= 1'b0;
          else if (avm_if.avm_writedata[CTRL_START_BIT]) sl_run <= 1'b1;
        end
        REG_PL: begin
          sl_period[15:0] <= avm_if.avm_writedata;
          sl_cnt          <= {sl_period[31:16], avm_if.avm_writedata};
        end
        REG_PH: begin
          sl_period[31:16] <= avm_if.avm_writedata;
          sl_cnt           <= {avm_if.avm_writedata, sl_period[15:0]};
        end
        REG_SL, REG_SH: sl_snap <= sl_cnt;
        default: ;
      endcase
    end
    if (avm_if.avm_chipselect && avm_if.avm_write_n) begin
      case (avm_if.avm_address)
        REG_ST:   sl_rdata <= {15'd0, sl_to};
        REG_CTRL: sl_rdata <= {12'd0, sl_ctrl};
        REG_PL:   sl_rdata <= sl_period[15:0];
        REG_PH:   sl_rdata <= sl_period[31:16];
        REG_SL:   sl_rdata <= sl_snap[15:0];
        REG_SH:   sl_rdata <= sl_snap[31:16];
        default:  sl_rdata <= '0;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboards
  logic [18:0] exp_wr[$];
  logic [2:0]  exp_rd[$];
  logic [31:0] exp_snap[$];

  int          cyc = 0;
  int          n_status = 0;
  int          n_wr = 0;
  int          n_pulse = 0;
  int          n_snap = 0;
  logic [2:0]  last_wr_addr = '0;
  int          last_wr_cyc = 0;
  logic        chk_irq_low = 1'b0;
  logic        prev_sv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (chk_irq_low) check("irq_low_in_clr_gap", 64'(avm_if.timer_irq), 0);
      chk_irq_low = 1'b0;
      if (avm_if.avm_chipselect && !avm_if.avm_write_n) begin
        n_wr++;
        if (avm_if.avm_address == REG_ST) begin
          n_status++;
          check("status_wdata", 64'(avm_if.avm_writedata), 0);
          chk_irq_low = 1'b1;
        end else begin
          if (exp_wr.size() == 0) check("write_unexpected", 64'(exp_wr.size()), 1);
          else check("bus_write", 64'({avm_if.avm_address, avm_if.avm_writedata}),
                     64'(exp_wr.pop_front()));
          if (avm_if.avm_address == REG_SL) exp_snap.push_back(sl_cnt);
          if (avm_if.avm_address == REG_CTRL && last_wr_addr == REG_PH)
            check("gap_before_ctrl", 64'(cyc - last_wr_cyc), 2);
        end
        last_wr_addr = avm_if.avm_address;
        last_wr_cyc  = cyc;
      end
      if (avm_if.avm_chipselect && avm_if.avm_write_n) begin
        if (exp_rd.size() == 0) check("read_unexpected", 64'(exp_rd.size()), 1);
        else check("bus_read_addr", 64'(avm_if.avm_address), 64'(exp_rd.pop_front()));
      end
      if (tick_pulse) n_pulse++;
      if (snap_valid) begin
        n_snap++;
        check("snap_valid_one_cycle", 64'(prev_sv), 0);
        if (exp_snap.size() == 0) check("snap_unexpected", 64'(exp_snap.size()), 1);
        else check("snap_value", 64'(snap_value), 64'(exp_snap.pop_front()));
      end
      prev_sv = snap_valid;
    end
  end

  task automatic start_timer(input logic [31:0] p);
    exp_wr.push_back({REG_PL, p[15:0]});
    exp_wr.push_back({REG_PH, p[31:16]});
    exp_wr.push_back({REG_CTRL, 16'(CTRL_RUN_DEF)});
    cfg_period = p;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic stop_timer();
    exp_wr.push_back({REG_CTRL, 16'(CTRL_STP_DEF)});
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("stop_reaches_idle", 64'(busy), 0);
  endtask

  task automatic wait_running();
    for (int i = 0; i < 40 && !running; i++) @(negedge clk);
    check("running_set", 64'(running), 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    int s0;
    int p0;
    int w0;

    repeat (3) @(negedge clk);
    check("rst_chipselect", 64'(avm_if.avm_chipselect), 0);
    check("rst_write_n", 64'(avm_if.avm_write_n), 1);
    check("rst_address", 64'(avm_if.avm_address), 0);
    check("rst_writedata", 64'(avm_if.avm_writedata), 0);
    check("rst_flags", 64'({busy, running, tick_pulse, snap_valid, cfg_err}), 0);
    check("rst_tick_count", 64'(tick_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Program period 9 and start; running appears on the fifth edge after the pulse
    start_timer(32'h0000_0009);
    n = 1;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("run_latency", 64'(n), 5);
    check("cfg_writes_done", 64'(exp_wr.size()), 0);
    check("tick_count_after_start", 64'(tick_count), 0);

    // Three timeouts serviced
    for (int i = 0; i < 100 && n_pulse < 3; i++) @(negedge clk);
    check("tick_count_3", 64'(tick_count), 3);
    check("status_writes_3", 64'(n_status), 3);
    check("tick_pulses_3", 64'(n_pulse), 3);

    // Snapshot mid-count
    repeat (3) @(negedge clk);
    exp_wr.push_back({REG_SL, 16'h0000});
    exp_rd.push_back(REG_SL);
    exp_rd.push_back(REG_SH);
    cfg_snap = 1'b1;
    @(negedge clk);
    cfg_snap = 1'b0;
    for (int i = 0; i < 40 && n_snap < 1; i++) @(negedge clk);
    check("snap_count", 64'(n_snap), 1);
    check("snap_reads_done", 64'(exp_rd.size()), 0);

    // Stop in the same cycle the IRQ rises
    for (int i = 0; i < 40 && avm_if.timer_irq; i++) @(negedge clk);
    for (int i = 0; i < 40 && !avm_if.timer_irq; i++) @(negedge clk);
    check("irq_rise_seen", 64'(avm_if.timer_irq), 1);
    t0 = int'(tick_count);
    s0 = n_status;
    stop_timer();
    check("stop_tick_hold", 64'(tick_count), 64'(t0));
    check("stop_running_clr", 64'(running), 0);
    check("stop_no_status_wr", 64'(n_status), 64'(s0));

    // Zero period is rejected with an error pulse and no bus traffic
    w0 = n_wr;
    cfg_period = '0;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    check("cfg_err_pulse", 64'({cfg_err, busy}), 64'(2'b10));
    @(negedge clk);
    check("cfg_err_one_cycle", 64'(cfg_err), 0);
    repeat (3) @(negedge clk);
    check("zero_period_no_bus", 64'(n_wr), 64'(w0));

    // Second start during WR_PH is ignored
    start_timer(32'h0000_0009);
    @(negedge clk);
    cfg_period = 32'h1234_5678;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    wait_running();
    check("restart_writes_done", 64'(exp_wr.size()), 0);
    check("restart_tick_clr", 64'(tick_count), 0);
    p0 = n_pulse;
    for (int i = 0; i < 40 && n_pulse < p0 + 1; i++) @(negedge clk);
    check("stale_irq_tick", 64'(tick_count), 1);
    stop_timer();
    check("stop2_running_clr", 64'(running), 0);

    // Reset while WR_PH is on the bus
    exp_wr.push_back({REG_PL, 16'h0005});
    cfg_period = 32'h0000_0005;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_bus_idle", 64'({avm_if.avm_chipselect, avm_if.avm_write_n}), 64'(2'b01));
    check("mid_rst_state", 64'({busy, running}), 0);
    check("mid_rst_tick", 64'(tick_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", 64'({busy, avm_if.avm_chipselect}), 0);
    check("sb_writes_empty", 64'(exp_wr.size()), 0);
    check("sb_snaps_empty", 64'(exp_snap.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
